// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the receive-side sequencer and the decoder side:
// packet-kind codes, the per-request status codes and the sequencer states.
package rx_ctrl_pkg;

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_DATA   = 2'b11;
  localparam logic [1:0] KIND_HSHAKE = 2'b10;

  typedef enum logic [2:0] {
    RX_OK       = 3'd0,
    RX_TIMEOUT  = 3'd1,
    RX_PID_ERR  = 3'd2,
    RX_CRC_ERR  = 3'd3,
    RX_KIND_ERR = 3'd4
  } rx_status_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LISTEN,
    ST_RECV,
    ST_PIDACK,
    ST_ABORT,
    ST_DONE
  } rx_state_t;

  // A bad CRC outranks a wrong kind; a request that expected no packet
  // treats any received packet as the wrong kind.
  function automatic rx_status_t resolve_verdict(input logic       crc_good,
                                                 input logic [1:0] got_kind,
                                                 input logic [1:0] want_kind);
    rx_status_t result;
    if (!crc_good) begin
      result = RX_CRC_ERR;
    end else if ((want_kind == KIND_NONE) || (got_kind != want_kind)) begin
      result = RX_KIND_ERR;
    end else begin
      result = RX_OK;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_timer.sv
// Shared wait timer for the LISTEN and RECV windows. The limit is chosen at
// run time by the sequencer; expired is a registered one-cycle pulse that
// lands the cycle after the terminal count limit-1 was reached.
module rx_timer #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count enabled cycles, wrap at the terminal count and flag it for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      if (count == (limit - WIDTH'(1))) begin
        count   <= '0;
        expired <= 1'b1;
      end else begin
        count   <= count + WIDTH'(1);
        expired <= 1'b0;
      end
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive-side sequencer: arms the decoder/CRC pair for one packet per
// request, bounds the listen and receive phases with a timer, collects the
// PID and CRC verdicts and reports one status per request.
module rx_packet_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int LISTEN_CYCLES = 255,
  parameter int RECV_CYCLES   = 8400,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_req,
  input  logic [1:0] rx_expect,
  input  logic       pkt_start,
  input  logic       bs_decoder_wait,
  input  logic       PID_error,
  input  logic       pid_done,
  input  logic [1:0] pkt_kind,
  input  logic       crc_done,
  input  logic       crc_ok,
  output logic       abort,
  output logic       rc_PIDerror,
  output logic       rx_busy,
  output logic       rx_done,
  output logic [2:0] rx_status,
  output logic       rx_give_up
);

  localparam int TIMER_MAX = (LISTEN_CYCLES > RECV_CYCLES) ? LISTEN_CYCLES : RECV_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int CNT_W     = $clog2(MAX_RETRY + 1);

  rx_state_t          state;
  rx_status_t         status_q;
  logic [1:0]         expect_q;
  logic               pid_seen;
  logic [1:0]         kind_q;
  logic               crc_seen;
  logic               crc_ok_q;
  logic [CNT_W-1:0]   err_count;

  logic               timer_clear;
  logic               timer_en;
  logic [TIMER_W-1:0] timer_limit;
  logic               timer_expired;

  logic               pid_now;
  logic               crc_now;
  logic [1:0]         kind_now;
  logic               crc_good_now;
  rx_status_t         verdict;

  // Timer runs only while waiting for a packet or its verdicts; it restarts on packet start
  always_comb begin
    timer_en    = (state == ST_LISTEN) || (state == ST_RECV);
    timer_clear = !timer_en || ((state == ST_LISTEN) && pkt_start);
    timer_limit = (state == ST_RECV) ? TIMER_W'(RECV_CYCLES) : TIMER_W'(LISTEN_CYCLES);
  end

  rx_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  // Merge stored verdicts with this cycle's pulses so same-cycle arrivals complete at once
  always_comb begin
    pid_now      = pid_seen || pid_done;
    crc_now      = crc_seen || crc_done;
    kind_now     = pid_done ? pkt_kind : kind_q;
    crc_good_now = crc_done ? crc_ok : crc_ok_q;
    verdict      = resolve_verdict(crc_good_now, kind_now, expect_q);
  end

  // Sequencer with registered Moore outputs and the per-request status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      status_q    <= RX_OK;
      expect_q    <= KIND_NONE;
      pid_seen    <= 1'b0;
      kind_q      <= KIND_NONE;
      crc_seen    <= 1'b0;
      crc_ok_q    <= 1'b0;
      abort       <= 1'b0;
      rc_PIDerror <= 1'b0;
      rx_busy     <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      abort       <= 1'b0;
      rc_PIDerror <= 1'b0;
      rx_done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_req) begin
            state    <= ST_ARM;
            expect_q <= rx_expect;
            rx_busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (bs_decoder_wait) begin
            state <= ST_LISTEN;
          end else begin
            abort <= 1'b1;
          end
        end
        ST_LISTEN: begin
          if (pkt_start) begin
            state    <= ST_RECV;
            pid_seen <= 1'b0;
            crc_seen <= 1'b0;
          end else if (timer_expired) begin
            state    <= ST_DONE;
            rx_done  <= 1'b1;
            status_q <= (expect_q == KIND_NONE) ? RX_OK : RX_TIMEOUT;
          end
        end
        ST_RECV: begin
          if (pid_done) begin
            pid_seen <= 1'b1;
            kind_q   <= pkt_kind;
          end
          if (crc_done) begin
            crc_seen <= 1'b1;
            crc_ok_q <= crc_ok;
          end
          if (PID_error) begin
            state       <= ST_PIDACK;
            rc_PIDerror <= 1'b1;
          end else if (pid_now && crc_now) begin
            state    <= ST_DONE;
            rx_done  <= 1'b1;
            status_q <= verdict;
          end else if (timer_expired) begin
            state <= ST_ABORT;
            abort <= 1'b1;
          end
        end
        ST_PIDACK: begin
          state    <= ST_DONE;
          rx_done  <= 1'b1;
          status_q <= RX_PID_ERR;
        end
        ST_ABORT: begin
          state    <= ST_DONE;
          rx_done  <= 1'b1;
          status_q <= RX_TIMEOUT;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Consecutive-error count: cleared by a good request, saturating otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (state == ST_DONE) begin
      if (status_q == RX_OK) begin
        err_count <= '0;
      end else if (err_count != CNT_W'(MAX_RETRY)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign rx_status  = status_q;
  assign rx_give_up = (err_count == CNT_W'(MAX_RETRY));

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Bench for rx_packet_ctrl: a table of hand-derived transactions, randomized
// transactions checked against a cycle-arithmetic reference model, and
// hand sequences for reset and request-in-DONE corner cases.
module tb_rx_packet_ctrl;

  localparam int LISTEN = 4;
  localparam int RECV   = 40;
  localparam int MAXR   = 3;
  localparam int NEVER  = 1000;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_DATA = 2'b11;
  localparam logic [1:0] K_HS   = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_req = 1'b0;
  logic [1:0] rx_expect = 2'b00;
  logic       pkt_start = 1'b0;
  logic       bs_decoder_wait = 1'b1;
  logic       PID_error = 1'b0;
  logic       pid_done = 1'b0;
  logic [1:0] pkt_kind = 2'b00;
  logic       crc_done = 1'b0;
  logic       crc_ok = 1'b0;
  logic       abort;
  logic       rc_PIDerror;
  logic       rx_busy;
  logic       rx_done;
  logic [2:0] rx_status;
  logic       rx_give_up;

  rx_packet_ctrl #(
    .LISTEN_CYCLES (LISTEN),
    .RECV_CYCLES   (RECV),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_req          (rx_req),
    .rx_expect       (rx_expect),
    .pkt_start       (pkt_start),
    .bs_decoder_wait (bs_decoder_wait),
    .PID_error       (PID_error),
    .pid_done        (pid_done),
    .pkt_kind        (pkt_kind),
    .crc_done        (crc_done),
    .crc_ok          (crc_ok),
    .abort           (abort),
    .rc_PIDerror     (rc_PIDerror),
    .rx_busy         (rx_busy),
    .rx_done         (rx_done),
    .rx_status       (rx_status),
    .rx_give_up      (rx_give_up)
  );

  always #5 clk = ~clk;

  // One request: times are in cycles; start_at is relative to LISTEN entry,
  // pid_at/crc_at/err_at relative to RECV entry; NEVER means no event.
  typedef struct {
    logic [1:0] exp_kind;
    int         wait_low;
    int         start_at;
    int         pid_at;
    int         crc_at;
    logic [1:0] kind;
    logic       crc_good;
    int         err_at;
  } txn_t;

  typedef struct {
    txn_t t;
    int   status;
    int   done_at;
    int   aborts;
    int   acks;
    int   give_up;
  } vec_t;

  int   tests = 0;
  int   failures = 0;
  int   model_count = 0;
  int   obs_status, obs_done, obs_aborts, obs_acks, obs_busy_after, obs_give_up;
  vec_t vecs[14];

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] ek, input int w, input int s, input int p,
                               input int c, input logic [1:0] k, input logic ok, input int e,
                               input int st, input int d, input int ab, input int ak,
                               input int gu);
    vec_t v;
    v.t.exp_kind = ek; v.t.wait_low = w; v.t.start_at = s; v.t.pid_at = p;
    v.t.crc_at = c; v.t.kind = k; v.t.crc_good = ok; v.t.err_at = e;
    v.status = st; v.done_at = d; v.aborts = ab; v.acks = ak; v.give_up = gu;
    return v;
  endfunction

  // Reference model: outcome and completion cycle derived from the timing rules
  function automatic void model(input txn_t t, output int st, output int d,
                                output int ab, output int ak);
    int lis, rcv, last;
    lis = t.wait_low + 2;
    ab  = t.wait_low;
    ak  = 0;
    if (t.start_at > LISTEN) begin
      d  = lis + LISTEN + 1;
      st = (t.exp_kind == K_NONE) ? 0 : 1;
    end else begin
      rcv  = lis + t.start_at + 1;
      last = (t.pid_at > t.crc_at) ? t.pid_at : t.crc_at;
      if (t.err_at <= last && t.err_at <= RECV) begin
        d = rcv + t.err_at + 2; st = 2; ak = 1;
      end else if (last <= RECV) begin
        d = rcv + last + 1;
        if (!t.crc_good) st = 3;
        else if (t.exp_kind == K_NONE || t.kind != t.exp_kind) st = 4;
        else st = 0;
      end else begin
        d = rcv + RECV + 2; st = 1; ab = ab + 1;
      end
    end
  endfunction

  function automatic int nextCount(input int cnt, input int st);
    if (st == 0) return 0;
    return (cnt >= MAXR) ? MAXR : cnt + 1;
  endfunction

  task automatic idleInputs();
    rx_req = 1'b0; pkt_start = 1'b0; bs_decoder_wait = 1'b1; PID_error = 1'b0;
    pid_done = 1'b0; crc_done = 1'b0;
  endtask

  // Drive one request cycle by cycle as the datapath would, recording what the DUT reports
  task automatic applyStimulus(input txn_t t);
    int  lis, rcv;
    bit  pe_active;
    lis = t.wait_low + 2;
    rcv = lis + t.start_at + 1;
    obs_done = -1; obs_status = -1; obs_aborts = 0; obs_acks = 0;
    pe_active = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (abort) obs_aborts++;
      if (rc_PIDerror) begin obs_acks++; pe_active = 1'b0; end
      if (rx_done) begin obs_done = c; obs_status = int'(rx_status); break; end
      rx_req          = (c == 0);
      rx_expect       = t.exp_kind;
      bs_decoder_wait = !(c >= 1 && c <= t.wait_low);
      pkt_start       = (t.start_at != NEVER) && (c == lis + t.start_at);
      pid_done        = (c == rcv + t.pid_at);
      pkt_kind        = t.kind;
      crc_done        = (c == rcv + t.crc_at);
      crc_ok          = t.crc_good;
      if (t.err_at != NEVER && c == rcv + t.err_at) pe_active = 1'b1;
      PID_error       = pe_active;
    end
    idleInputs();
    @(negedge clk);
    obs_busy_after = rx_busy;
    obs_give_up    = rx_give_up;
  endtask

  task automatic checkTxn(input string tag, input int st, input int d, input int ab,
                          input int ak, input int gu);
    checkOutput({tag, ".status"}, obs_status, st);
    checkOutput({tag, ".done_cycle"}, obs_done, d);
    checkOutput({tag, ".abort_cycles"}, obs_aborts, ab);
    checkOutput({tag, ".pidack_cycles"}, obs_acks, ak);
    checkOutput({tag, ".give_up"}, obs_give_up, gu);
    checkOutput({tag, ".busy_after"}, obs_busy_after, 0);
  endtask

  function automatic logic [1:0] pickKind();
    case ($urandom_range(0, 2))
      0:       return K_NONE;
      1:       return K_DATA;
      default: return K_HS;
    endcase
  endfunction

  initial begin
    txn_t t;
    int   st, d, ab, ak;

    // Hand-derived table: statuses OK 0, TIMEOUT 1, PID_ERR 2, CRC_ERR 3, KIND_ERR 4
    vecs[0]  = mkv(K_DATA, 0, 2,     3,     3,     K_DATA, 1'b1, NEVER, 0, 9,  0, 0, 0);
    vecs[1]  = mkv(K_HS,   0, 0,     0,     3,     K_HS,   1'b0, NEVER, 3, 7,  0, 0, 0);
    vecs[2]  = mkv(K_DATA, 0, 1,     2,     2,     K_DATA, 1'b1, 2,     2, 8,  0, 1, 0);
    vecs[3]  = mkv(K_DATA, 0, NEVER, NEVER, NEVER, K_DATA, 1'b1, NEVER, 1, 7,  0, 0, 1);
    vecs[4]  = mkv(K_NONE, 0, NEVER, NEVER, NEVER, K_DATA, 1'b1, NEVER, 0, 7,  0, 0, 0);
    vecs[5]  = mkv(K_DATA, 3, 0,     1,     1,     K_DATA, 1'b1, NEVER, 0, 8,  3, 0, 0);
    vecs[6]  = mkv(K_DATA, 0, 0,     0,     0,     K_HS,   1'b1, NEVER, 4, 4,  0, 0, 0);
    vecs[7]  = mkv(K_DATA, 0, 0,     0,     0,     K_HS,   1'b1, NEVER, 4, 4,  0, 0, 0);
    vecs[8]  = mkv(K_DATA, 0, 0,     0,     0,     K_HS,   1'b1, NEVER, 4, 4,  0, 0, 1);
    vecs[9]  = mkv(K_NONE, 0, 0,     0,     0,     K_NONE, 1'b1, NEVER, 4, 4,  0, 0, 1);
    vecs[10] = mkv(K_DATA, 0, 0,     2,     1,     K_DATA, 1'b1, NEVER, 0, 6,  0, 0, 0);
    vecs[11] = mkv(K_DATA, 0, 0,     1,     NEVER, K_DATA, 1'b1, NEVER, 1, 45, 1, 0, 0);
    vecs[12] = mkv(K_DATA, 0, 4,     0,     0,     K_DATA, 1'b1, NEVER, 0, 8,  0, 0, 0);
    vecs[13] = mkv(K_DATA, 0, 0,     1,     0,     K_HS,   1'b0, NEVER, 3, 5,  0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset.abort", abort, 0);
    checkOutput("reset.rc_PIDerror", rc_PIDerror, 0);
    checkOutput("reset.busy", rx_busy, 0);
    checkOutput("reset.done", rx_done, 0);
    checkOutput("reset.status", rx_status, 0);
    checkOutput("reset.give_up", rx_give_up, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].t);
      checkTxn($sformatf("vec%0d", i), vecs[i].status, vecs[i].done_at,
               vecs[i].aborts, vecs[i].acks, vecs[i].give_up);
      model_count = nextCount(model_count, vecs[i].status);
    end

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      t.exp_kind = pickKind();
      t.kind     = ($urandom_range(0, 9) < 7) ? t.exp_kind : pickKind();
      t.wait_low = $urandom_range(0, 3);
      t.start_at = $urandom_range(0, 6);
      if (t.start_at > LISTEN) t.start_at = NEVER;
      t.pid_at   = $urandom_range(0, 6);
      t.crc_at   = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 6);
      t.crc_good = ($urandom_range(0, 3) != 0);
      t.err_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : NEVER;
      model(t, st, d, ab, ak);
      model_count = nextCount(model_count, st);
      applyStimulus(t);
      checkTxn($sformatf("rnd%0d", i), st, d, ab, ak, (model_count == MAXR) ? 1 : 0);
    end

    // Drive the error count to saturation, then reset in the middle of RECV
    t = vecs[6].t;
    for (int i = 0; i < 3; i++) begin
      model(t, st, d, ab, ak);
      model_count = nextCount(model_count, st);
      applyStimulus(t);
      checkTxn($sformatf("sat%0d", i), st, d, ab, ak, (model_count == MAXR) ? 1 : 0);
    end
    @(negedge clk); rx_req = 1'b1; rx_expect = K_DATA;
    @(negedge clk); rx_req = 1'b0;
    @(negedge clk); pkt_start = 1'b1;
    @(negedge clk); pkt_start = 1'b0;
    checkOutput("recv.busy", rx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.abort", abort, 0);
    checkOutput("midreset.rc_PIDerror", rc_PIDerror, 0);
    checkOutput("midreset.busy", rx_busy, 0);
    checkOutput("midreset.done", rx_done, 0);
    checkOutput("midreset.status", rx_status, 0);
    checkOutput("midreset.give_up", rx_give_up, 0);
    model_count = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // A request held during DONE must not start a new one
    rx_req = 1'b1; rx_expect = K_DATA; pkt_kind = K_DATA; crc_ok = 1'b1;
    @(negedge clk); rx_req = 1'b0;
    @(negedge clk); pkt_start = 1'b1;
    @(negedge clk); pkt_start = 1'b0; pid_done = 1'b1; crc_done = 1'b1;
    @(negedge clk); pid_done = 1'b0; crc_done = 1'b0;
    checkOutput("reqdone.done", rx_done, 1);
    checkOutput("reqdone.status", rx_status, 0);
    rx_req = 1'b1;
    @(negedge clk); rx_req = 1'b0;
    checkOutput("reqdone.busy", rx_busy, 0);
    @(negedge clk);
    checkOutput("reqdone.busy_later", rx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Receive-side sequencer for the USB receive path. It arms the `bs_decoder`/`rc_crc` pair for one packet per request from the transaction layer and bounds the wait for the packet and its reception with a timeout. It collects PID and CRC verdicts, acknowledges PID errors back to the decoder and returns a single status per request. It sits between the protocol FSM's transaction logic and the receive datapath, and owns the datapath `abort` line.

## Interface
- `LISTEN_CYCLES`, 255, max cycles waiting for a packet start after arming
- `RECV_CYCLES`, 8400, max cycles from packet start to both verdicts
- `MAX_RETRY`, 3, consecutive-error count at which `rx_give_up` asserts

- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_req`  in  1  request to receive one packet; sampled only in IDLE
- `rx_expect`  in  2  expected kind: NONE 2'b00, DATA 2'b11, HSHAKE 2'b10; latched with `rx_req`
- `pkt_start`  in  1  one-cycle pulse from the bit unstuffer on SYNC detect
- `bs_decoder_wait`  in  1  decoder is idle
- `PID_error`  in  1  decoder reports an invalid PID; held until acknowledged
- `pid_done`  in  1  one-cycle pulse; `pkt_kind` valid
- `pkt_kind`  in  2  decoded packet kind, same encoding as `rx_expect`
- `crc_done`  in  1  one-cycle pulse from `rc_crc`; `crc_ok` valid
- `crc_ok`  in  1  CRC matched
- `abort`  out  1  datapath abort to decoder and CRC
- `rc_PIDerror`  out  1  PID-error acknowledge to decoder
- `rx_busy`  out  1  high in every state except IDLE
- `rx_done`  out  1  one-cycle completion pulse
- `rx_status`  out  3  OK 0, TIMEOUT 1, PID_ERR 2, CRC_ERR 3, KIND_ERR 4; stable from `rx_done` until the next `rx_done`
- `rx_give_up`  out  1  consecutive-error count has reached `MAX_RETRY`

## Operation
- States: IDLE, ARM, LISTEN, RECV, PIDACK, ABORT, DONE.
- IDLE → ARM on `rx_req`. Latch `rx_expect`.
- ARM: if `bs_decoder_wait`, go to LISTEN. Otherwise assert `abort` and stay; re-check every cycle.
- LISTEN: the timer counts.
  - `pkt_start` → RECV. The timer clears and the verdict flags clear.
  - Timer expiry without `pkt_start` → DONE. Status is OK if expect is NONE, else TIMEOUT. No abort.
  - `pkt_start` wins over expiry in the same cycle.
- RECV: record `pid_done` (flag + kind) and `crc_done` (flag + ok) in either order, including the same cycle.
  - `PID_error` → PIDACK. This has priority over any same-cycle done pulse.
  - Both flags set (counting the current cycle's pulses) → DONE. Status is resolved in priority order:
    1. CRC_ERR if `crc_ok` = 0,
    2. else KIND_ERR if kind ≠ expect (expect NONE always yields KIND_ERR),
    3. else OK.
  - Expiry of `RECV_CYCLES` → ABORT.
- PIDACK: `rc_PIDerror` = 1 for exactly one cycle; status PID_ERR; → DONE.
- ABORT: `abort` = 1 for one cycle; status TIMEOUT; → DONE.
- DONE: `rx_done` = 1 and update the error counter; → IDLE. A `rx_req` in DONE is ignored.
- Error counter: width $clog2(MAX_RETRY+1). Cleared on OK. Incremented on any other status, saturating at `MAX_RETRY`. `rx_give_up` = (count == `MAX_RETRY`).
- Reset mid-operation: return to IDLE immediately. All outputs, counters, flags and status clear.

## Timing
- Reset values: state IDLE; `abort`, `rc_PIDerror`, `rx_busy`, `rx_done`, `rx_give_up` = 0; `rx_status` = 0; error count 0.
- `abort`, `rc_PIDerror`, `rx_done` and `rx_busy` are Moore outputs decoded from the registered state. They are never functions of inputs.
- Latencies:
  - `rx_req` at cycle N → ARM at N+1 → LISTEN at N+2 (decoder idle).
  - Last verdict pulse at cycle M → `rx_done` at M+1.
  - `PID_error` first seen at M → `rc_PIDerror` at M+1 → `rx_done` at M+2.
- Timer: width $clog2(max(LISTEN_CYCLES, RECV_CYCLES)+1). Counts 0..limit-1; expires in the cycle count == limit-1.
- LISTEN timeout: `rx_done` exactly `LISTEN_CYCLES`+1 cycles after LISTEN entry.

## Structure
- Shared package `rx_ctrl_pkg` holds:
  - packet-kind constants NONE/DATA/HSHAKE,
  - the `rx_status_t` enum,
  - the state enum.
  - The kind constants are shared with the decoder side.
- Sub-module `rx_timer`: clear/enable inputs, runtime-selected limit, one-cycle `expired` output. It is instantiated once.

## Test plan
- Decoder idle, `rx_req` with expect DATA, `pkt_start` at LISTEN+5, `crc_done`+`crc_ok`=1 and `pid_done` with kind DATA in the same cycle → `rx_done` next cycle, status 0, `abort` never high, count 0.
- Expect HSHAKE, `pid_done` kind HSHAKE then `crc_done` `crc_ok`=0 three cycles later → status CRC_ERR (3), count 1.
- `PID_error` held high in RECV together with `crc_done` → `rc_PIDerror` high exactly one cycle, status PID_ERR (2), decoder drops `PID_error` afterward.
- `LISTEN_CYCLES`=4, no `pkt_start` → expect DATA: status TIMEOUT at LISTEN+5, no abort; expect NONE: status OK.
- `bs_decoder_wait`=0 for 3 cycles after request → `abort` high 3 cycles, LISTEN entered the cycle after `bs_decoder_wait` rises.
- `MAX_RETRY`=3:
  - Four consecutive KIND_ERR → `rx_give_up` rises after the third and stays high after the fourth.
  - One OK then clears it.
  - `rst_n` low during RECV → all outputs 0 asynchronously.
